// File: rtl/tdc_multi_stamper.sv
// tdc_multi_stamper
//   Multi-channel TDC time stamper. Each hit channel has its edges detected
//   against the previous-cycle level. A qualifying edge captures
//   {channel, edge type, coarse count, fine code} into that channel's pending
//   slot. A round-robin arbiter moves one pending slot per cycle into an
//   output FIFO. The FIFO is first-word fall-through.
//
// Ports
//   iClk       - sole clock; all logic runs on the rising edge
//   iRst       - asynchronous, active-low reset
//   iEnable    - enables coarse counting and edge capture
//   iHit       - per-channel hit levels, already synchronous to iClk
//   iTaps      - per-channel thermometer snapshots; channel c at [c*NUM_TAPS +: NUM_TAPS]
//   oData      - FIFO head {channel, edge(1=rise), coarse, fine}, MSB first
//   oValid     - oData holds a valid FIFO head
//   iReady     - consumer accepts oData when oValid & iReady
//   oOverflow  - sticky flag; set once at least one event has been dropped
//   oDropCount - number of dropped events, saturating at 255
//
// Handshake: a word transfers on every rising edge where oValid & iReady are
// both high. While oValid=1 and iReady=0, oData holds its value. oValid never
// drops without a transfer, except on reset.
module tdc_multi_stamper #(
    parameter int NUM_CH     = 4,
    parameter int NUM_TAPS   = 120,
    parameter int FINE_W     = 7,
    parameter int COARSE_W   = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int EDGE_MODE  = 0,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int DW        = CH_W + 1 + COARSE_W + FINE_W
) (
    input  logic                       iClk,
    input  logic                       iRst,
    input  logic                       iEnable,
    input  logic [NUM_CH-1:0]          iHit,
    input  logic [NUM_CH*NUM_TAPS-1:0] iTaps,
    output logic [DW-1:0]              oData,
    output logic                       oValid,
    input  logic                       iReady,
    output logic                       oOverflow,
    output logic [7:0]                 oDropCount
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [COARSE_W-1:0] coarse_q;
    logic [NUM_CH-1:0]   hit_prev_q;
    logic [NUM_CH-1:0]   rise, fall, qual;
    logic [NUM_CH-1:0]   slot_full_q, slot_full_d, drop_vec;
    logic [DW-1:0]       slot_word_q [NUM_CH];
    logic [DW-1:0]       slot_word_d [NUM_CH];
    logic [CH_W-1:0]     rr_start_q, grant_ch;
    logic                grant_vld, fifo_full, push, pop;
    logic [DW-1:0]       fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [AW:0]         cnt_q;
    logic                ovf_q;
    logic [7:0]          drop_cnt_q, drop_cnt_d;
    logic [8:0]          n_drops, drop_sum;
    int                  idx;

    // Bubble-tolerant fine code: count ones instead of locating the edge.
    function automatic logic [FINE_W-1:0] popcount(input logic [NUM_TAPS-1:0] t);
        logic [FINE_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_TAPS; i++) n = n + FINE_W'(t[i]);
        return n;
    endfunction

    assign rise = iHit & ~hit_prev_q;
    assign fall = ~iHit & hit_prev_q;
    assign qual = !iEnable        ? '0   :
                  (EDGE_MODE == 0) ? rise :
                  (EDGE_MODE == 1) ? fall : (rise | fall);

    assign fifo_full = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign oValid    = (cnt_q != '0);
    assign pop       = oValid & iReady;
    // A grant is only made when the FIFO has room, so a push never meets a full FIFO.
    assign push      = grant_vld;

    // Round-robin search starting at the channel after the last grant.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        idx       = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(rr_start_q) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!grant_vld && !fifo_full && slot_full_q[CH_W'(idx)]) begin
                grant_vld = 1'b1;
                grant_ch  = CH_W'(idx);
            end
        end
    end

    // Slot update: the granted slot is cleared first, so a new edge on that
    // channel in the same cycle reloads it instead of being dropped. The fine
    // code is computed from the captured slice at capture time and stored with
    // the rest of the word.
    always_comb begin
        slot_full_d = slot_full_q;
        drop_vec    = '0;
        for (int i = 0; i < NUM_CH; i++) slot_word_d[i] = slot_word_q[i];
        if (grant_vld) slot_full_d[grant_ch] = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (qual[i]) begin
                if (slot_full_d[i]) begin
                    drop_vec[i] = 1'b1;
                end else begin
                    slot_full_d[i] = 1'b1;
                    slot_word_d[i] = {CH_W'(i), rise[i], coarse_q,
                                      popcount(iTaps[i*NUM_TAPS +: NUM_TAPS])};
                end
            end
        end
    end

    // Several channels may drop in the same cycle; each one counts.
    always_comb begin
        n_drops = '0;
        for (int i = 0; i < NUM_CH; i++) n_drops = n_drops + 9'(drop_vec[i]);
        drop_sum   = {1'b0, drop_cnt_q} + n_drops;
        drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            coarse_q    <= '0;
            hit_prev_q  <= '0;
            slot_full_q <= '0;
            for (int i = 0; i < NUM_CH; i++) slot_word_q[i] <= '0;
            rr_start_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            if (iEnable) coarse_q <= coarse_q + 1'b1;
            hit_prev_q  <= iHit;
            slot_full_q <= slot_full_d;
            for (int i = 0; i < NUM_CH; i++) slot_word_q[i] <= slot_word_d[i];
            if (push) begin
                wr_ptr_q   <= wr_ptr_q + 1'b1;
                rr_start_q <= (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (!push && pop) cnt_q <= cnt_q - 1'b1;
            if (|drop_vec) ovf_q <= 1'b1;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage only; validity is tracked by the pointers and count.
    always_ff @(posedge iClk) begin
        if (push) fifo_mem[wr_ptr_q] <= slot_word_q[grant_ch];
    end

    assign oData      = oValid ? fifo_mem[rd_ptr_q] : '0;
    assign oOverflow  = ovf_q;
    assign oDropCount = drop_cnt_q;

endmodule
